// File: rtl/core_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | core_ctrl_pkg: shared state, error encodings and helpers for core_ctrl |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package core_ctrl_pkg;

   typedef enum logic [2:0] {
      CTRL_BOOT   = 3'd0,
      CTRL_FETCH  = 3'd1,
      CTRL_DECODE = 3'd2,
      CTRL_EXEC   = 3'd3,
      CTRL_MEM    = 3'd4,
      CTRL_WB     = 3'd5,
      CTRL_HALT   = 3'd6
   } ctrl_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ILLEGAL  = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_MISALIGN = 2'd3
   } ctrl_err_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/core_ctrl_if.sv
// +----------------------------------------------------------------------+
// | core_ctrl_if: sequencer handshake bundle (memories, decoder, ALU, RF) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface core_ctrl_if;
   logic        imem_req;
   logic        imem_ack;
   logic        ir_we;
   logic        dec_illegal;
   logic        dec_is_load;
   logic        dec_is_store;
   logic        dec_wb;
   logic        ex_we;
   logic        br_taken;
   logic [31:0] br_target;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        rf_we;
   logic [31:0] pc;
   logic        retire;
   logic [31:0] instret;
   logic        halted;
   logic [1:0]  err_code;
   logic [2:0]  state;

   modport master (
      input  imem_ack, dec_illegal, dec_is_load, dec_is_store, dec_wb,
             br_taken, br_target, dmem_ack,
      output imem_req, ir_we, ex_we, dmem_req, dmem_we, rf_we, pc,
             retire, instret, halted, err_code, state
   );

   modport slave (
      output imem_ack, dec_illegal, dec_is_load, dec_is_store, dec_wb,
             br_taken, br_target, dmem_ack,
      input  imem_req, ir_we, ex_we, dmem_req, dmem_we, rf_we, pc,
             retire, instret, halted, err_code, state
   );
endinterface

`default_nettype wire

// File: rtl/core_ctrl_bus_timer.sv
// +----------------------------------------------------------------------+
// | bus_timer: counts unacknowledged request cycles, flags expiry        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic req_i,
   input  logic ack_i,
   output logic expired_o
);

   generate
      if (MEM_TIMEOUT == 0) begin : g_no_timeout
         assign expired_o = 1'b0;
      end else begin : g_timeout
         localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
         localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else if (clear_i || ack_i) begin
               cnt_q <= '0;
            end else if (req_i) begin
               cnt_q <= cnt_q + CW'(1);
            end
         end

         // cnt_q holds the number of earlier unacked cycles, so this is the final allowed one
         assign expired_o = req_i && !ack_i && (cnt_q == LAST);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/core_ctrl.sv
// +----------------------------------------------------------------------+
// | core_ctrl: multi-cycle rv32i sequencer (PC, strobes, fault halt)     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   core_ctrl_if.master   bus
);

   ctrl_state_e state_q, state_d;
   ctrl_err_e   err_q, err_d;
   logic [31:0] pc_q;
   logic [31:0] instret_q;
   logic [31:0] target_q;
   logic        taken_q;
   logic        halted_q;

   logic        in_fetch, in_mem, in_wb;
   logic        bus_req, bus_ack, expired;
   logic        wb_fault, pc_we;

   assign in_fetch = (state_q == CTRL_FETCH);
   assign in_mem   = (state_q == CTRL_MEM);
   assign in_wb    = (state_q == CTRL_WB);

   assign bus_req  = in_fetch || in_mem;
   assign bus_ack  = (in_fetch && bus.imem_ack) || (in_mem && bus.dmem_ack);
   assign wb_fault = taken_q && misaligned(target_q);
   assign pc_we    = in_wb && !wb_fault;

   bus_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_bus_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (!bus_req),
      .req_i     (bus_req),
      .ack_i     (bus_ack),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         CTRL_BOOT:   state_d = CTRL_FETCH;
         CTRL_FETCH: begin
            if (bus.imem_ack) begin
               state_d = CTRL_DECODE;
            end else if (expired) begin
               state_d = CTRL_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         CTRL_DECODE: begin
            if (bus.dec_illegal) begin
               state_d = CTRL_HALT;
               err_d   = ERR_ILLEGAL;
            end else begin
               state_d = CTRL_EXEC;
            end
         end
         CTRL_EXEC:
            state_d = (bus.dec_is_load || bus.dec_is_store) ? CTRL_MEM : CTRL_WB;
         CTRL_MEM: begin
            if (bus.dmem_ack) begin
               state_d = CTRL_WB;
            end else if (expired) begin
               state_d = CTRL_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         CTRL_WB: begin
            if (wb_fault) begin
               state_d = CTRL_HALT;
               err_d   = ERR_MISALIGN;
            end else begin
               state_d = CTRL_FETCH;
            end
         end
         CTRL_HALT:   state_d = CTRL_HALT;
         default:     state_d = CTRL_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CTRL_BOOT;
         err_q     <= ERR_NONE;
         pc_q      <= RESET_PC;
         instret_q <= 32'd0;
         taken_q   <= 1'b0;
         target_q  <= 32'd0;
         halted_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         halted_q <= (state_d == CTRL_HALT);
         if (state_q == CTRL_EXEC) begin
            taken_q  <= bus.br_taken;
            target_q <= bus.br_target;
         end
         // pc and instret move on the edge that ends WB, together with retire
         if (pc_we) begin
            pc_q      <= taken_q ? target_q : pc_q + PC_STEP;
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   // Strobes decode the registered state only, so an async reset drops them at once
   assign bus.imem_req = in_fetch;
   assign bus.ir_we    = in_fetch && bus.imem_ack;
   assign bus.ex_we    = (state_q == CTRL_EXEC);
   assign bus.dmem_req = in_mem;
   assign bus.dmem_we  = in_mem && bus.dec_is_store;
   assign bus.rf_we    = pc_we && bus.dec_wb && !bus.dec_is_store;
   assign bus.retire   = pc_we;
   assign bus.pc       = pc_q;
   assign bus.instret  = instret_q;
   assign bus.halted   = halted_q;
   assign bus.err_code = err_q;
   assign bus.state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_core_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_core_ctrl: scoreboard bench for the core_ctrl sequencer           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_core_ctrl;
   import core_ctrl_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TMO    = 4;

   typedef struct {
      logic [31:0] pc;
      logic        rf_we;
      int          lat;
      logic [31:0] next_pc;
      logic [31:0] instret;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   core_ctrl_if bus();

   core_ctrl #(
      .RESET_PC    (RST_PC),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_pc      = RST_PC;
   logic [31:0] m_instret = 32'd0;
   exp_t        sb[$];
   exp_t        pend;
   bit          pend_v = 1'b0;
   int          lat = 0;
   logic [2:0]  prev_state = 3'd0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] strobes();
      return 32'({bus.imem_req, bus.ir_we, bus.ex_we, bus.dmem_req,
                  bus.dmem_we, bus.rf_we, bus.retire});
   endfunction

   // Retire monitor: pops the scoreboard and checks pc/instret one cycle later
   always @(negedge clk) begin
      #1;
      if (rst) begin
         pend_v = 1'b0;
         lat    = 0;
      end else begin
         if (pend_v) begin
            chk("next_pc", bus.pc, pend.next_pc);
            chk("instret", bus.instret, pend.instret);
            pend_v = 1'b0;
         end
         if (bus.state == CTRL_FETCH && prev_state != CTRL_FETCH) lat = 1;
         else lat++;
         if (bus.retire) begin
            if (sb.size() == 0) begin
               chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
               pend = sb.pop_front();
               chk("wb_pc", bus.pc, pend.pc);
               chk("wb_rf_we", 32'(bus.rf_we), 32'(pend.rf_we));
               chk("latency", 32'(lat), 32'(pend.lat));
               pend_v = 1'b1;
            end
         end
      end
      prev_state = bus.state;
   end

   task automatic clear_inputs();
      bus.imem_ack     = 1'b0;
      bus.dmem_ack     = 1'b0;
      bus.dec_illegal  = 1'b0;
      bus.dec_is_load  = 1'b0;
      bus.dec_is_store = 1'b0;
      bus.dec_wb       = 1'b0;
      bus.br_taken     = 1'b0;
      bus.br_target    = 32'h0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      m_pc = RST_PC;
      m_instret = 32'd0;
      sb.delete();
      #1;
      chk("boot_state", 32'(bus.state), 32'(CTRL_BOOT));
      chk("boot_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      chk("first_req", 32'(bus.imem_req), 32'd1);
   endtask

   task automatic wait_fetch(output bit ok);
      int n = 0;
      ok = 1'b1;
      while (!bus.imem_req) begin
         if (n == 50) begin
            chk("fetch_wait", 32'd0, 32'd1);
            ok = 1'b0;
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_instr(input int iw, input bit ld, input bit st, input bit wbf,
                            input bit tk, input logic [31:0] tgt, input int dw);
      exp_t e;
      bit   ok;
      bit   fault = tk && (tgt[1:0] != 2'b00);
      wait_fetch(ok);
      if (!ok) return;
      chk("fetch_pc", bus.pc, m_pc);
      e.pc      = m_pc;
      e.rf_we   = wbf && !st;
      e.lat     = 4 + iw + ((ld || st) ? dw + 1 : 0);
      e.next_pc = tk ? tgt : m_pc + 32'd4;
      e.instret = m_instret + 32'd1;
      if (!fault) sb.push_back(e);
      for (int w = 0; w <= iw; w++) begin
         if (w > 0) @(negedge clk);
         bus.imem_ack = (w == iw);
         #1;
         chk("imem_req", 32'(bus.imem_req), 32'd1);
         if (w == iw) chk("ir_we", 32'(bus.ir_we), 32'd1);
      end
      @(negedge clk);
      bus.imem_ack     = 1'b0;
      bus.dec_is_load  = ld;
      bus.dec_is_store = st;
      bus.dec_wb       = wbf;
      #1 chk("decode_state", 32'(bus.state), 32'(CTRL_DECODE));
      @(negedge clk);
      bus.br_taken  = tk;
      bus.br_target = tgt;
      #1 chk("ex_we", 32'(bus.ex_we), 32'd1);
      @(negedge clk);
      bus.br_taken  = 1'b0;
      bus.br_target = 32'hDEAD_BEEF;
      if (ld || st) begin
         for (int w = 0; w <= dw; w++) begin
            if (w > 0) @(negedge clk);
            bus.dmem_ack = (w == dw);
            #1;
            chk("dmem_req", 32'(bus.dmem_req), 32'd1);
            chk("dmem_we", 32'(bus.dmem_we), 32'(st));
         end
         @(negedge clk);
         bus.dmem_ack = 1'b0;
      end
      if (fault) begin
         #1;
         chk("fault_rf_we", 32'(bus.rf_we), 32'd0);
         chk("fault_retire", 32'(bus.retire), 32'd0);
         @(negedge clk);
         #1;
         chk("misalign_state", 32'(bus.state), 32'(CTRL_HALT));
         chk("misalign_err", 32'(bus.err_code), 32'(ERR_MISALIGN));
         chk("misalign_pc", bus.pc, m_pc);
         chk("misalign_halted", 32'(bus.halted), 32'd1);
      end else begin
         m_pc      = e.next_pc;
         m_instret = e.instret;
      end
   endtask

   task automatic halt_hold(input string tag, input logic [1:0] err);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.imem_ack = 1'b1;
         bus.dmem_ack = 1'b1;
         #1;
         chk({tag, "_strobes"}, strobes(), 32'd0);
         chk({tag, "_err"}, 32'(bus.err_code), 32'(err));
         chk({tag, "_pc"}, bus.pc, m_pc);
         chk({tag, "_instret"}, bus.instret, m_instret);
      end
      clear_inputs();
   endtask

   initial begin
      bit ok;
      int n;
      clear_inputs();
      #2;
      chk("rst_state", 32'(bus.state), 32'(CTRL_BOOT));
      chk("rst_pc", bus.pc, RST_PC);
      chk("rst_instret", bus.instret, 32'd0);
      chk("rst_err", 32'(bus.err_code), 32'(ERR_NONE));
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_strobes", strobes(), 32'd0);
      release_reset();

      run_instr(0, 0, 0, 1, 0, 32'h0,         0);   // ALU op
      run_instr(1, 0, 0, 0, 0, 32'h0,         0);   // branch not taken
      run_instr(0, 0, 0, 0, 1, 32'h100,       0);   // branch taken
      run_instr(3, 0, 0, 1, 1, 32'h200,       0);   // jump, ack on last allowed cycle
      run_instr(0, 1, 0, 1, 0, 32'h0,         0);   // load, zero wait
      run_instr(0, 0, 1, 1, 0, 32'h0,         3);   // store, 3 wait cycles
      run_instr(2, 1, 0, 1, 0, 32'h0,         1);   // load, waits on both ports
      run_instr(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);   // jump to top of memory
      run_instr(0, 0, 0, 1, 0, 32'h0,         0);   // pc wraps to 0

      // Reset while a load is waiting in MEM
      wait_fetch(ok);
      bus.imem_ack = 1'b1;
      @(negedge clk);
      bus.imem_ack    = 1'b0;
      bus.dec_is_load = 1'b1;
      bus.dec_wb      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 chk("abort_in_mem", 32'(bus.dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_strobes", strobes(), 32'd0);
      chk("abort_pc", bus.pc, RST_PC);
      chk("abort_instret", bus.instret, 32'd0);
      chk("abort_state", 32'(bus.state), 32'(CTRL_BOOT));
      clear_inputs();
      release_reset();
      run_instr(0, 0, 0, 1, 0, 32'h0, 0);

      // Illegal instruction
      wait_fetch(ok);
      bus.imem_ack = 1'b1;
      @(negedge clk);
      bus.imem_ack    = 1'b0;
      bus.dec_illegal = 1'b1;
      @(negedge clk);
      #1;
      chk("illegal_state", 32'(bus.state), 32'(CTRL_HALT));
      chk("illegal_halted", 32'(bus.halted), 32'd1);
      halt_hold("illegal", ERR_ILLEGAL);
      rst = 1'b1;
      release_reset();

      // Misaligned jump target
      run_instr(0, 0, 0, 1, 0, 32'h0, 0);
      run_instr(0, 0, 0, 1, 1, 32'h102, 0);
      halt_hold("misalign", ERR_MISALIGN);
      rst = 1'b1;
      release_reset();

      // Instruction fetch never acknowledged
      run_instr(0, 0, 0, 1, 0, 32'h0, 0);
      wait_fetch(ok);
      n = 0;
      while (bus.imem_req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_cycles", 32'(n), 32'(TMO));
      #1;
      chk("timeout_state", 32'(bus.state), 32'(CTRL_HALT));
      chk("timeout_halted", 32'(bus.halted), 32'd1);
      halt_hold("timeout", ERR_TIMEOUT);
      rst = 1'b1;
      release_reset();
      run_instr(0, 0, 0, 1, 0, 32'h0, 0);

      @(negedge clk);
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
